cr_tlvp_ob_merge: RTL and testbench
===================================

# cr_tlvp_ob_merge

Outbound TLV merger that sits directly downstream of the TLV splitter/user-module pair. It reads whole TLVs from the pass-through FIFO and from the user-module outbound FIFO. It re-interleaves them in the original arrival order, as given by a 1-bit order FIFO written by the splitter, and drives a single registered valid/ready stream toward the outbound AXI4-stream packer. TLV atomicity is enforced: once a TLV starts on one source, only that source is read until its end-of-TLV word.

## Interface
- N_DATA_BITS, 64: width of TLV data words on both sources and the output.
- MAX_TLV_WORDS, 256: maximum legal TLV length in words; longer TLVs are truncated and flagged.
- clk  input  1  core clock; all logic is on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ord_empty  input  1  order FIFO empty (show-ahead FIFO; head is valid when !empty).
- ord_src  input  1  head of the order FIFO: 0 = pass-through, 1 = user.
- ord_rd  output  1  pops the order FIFO head.
- pt_empty  input  1  pass-through FIFO empty (show-ahead).
- pt_data  input  N_DATA_BITS  pass-through head word.
- pt_eot  input  1  head word is the last word of its TLV.
- pt_rd  output  1  pops the pass-through FIFO.
- usr_empty, usr_data, usr_eot, usr_rd: same as the pt_* ports, for the user outbound FIFO.
- ob_tvalid  output  1  output word valid.
- ob_tready  input  1  downstream accepts the word.
- ob_tdata  output  N_DATA_BITS  output word.
- ob_tlast  output  1  last word of the TLV.
- ob_tid  output  1  source of the word (0 = pt, 1 = usr).
- merge_error  output  1  sticky oversize-TLV flag; cleared only by reset.
- tlv_count  output  16  count of TLVs emitted; wraps.

## Operation
- States: IDLE, XFER, DRAIN.
- IDLE:
  - When !ord_empty: assert ord_rd for one cycle, latch ord_src into cur_src, clear word_cnt, then go to XFER.
- XFER:
  - A read is allowed when the selected source is !empty and the output register can load: !ob_tvalid || ob_tready.
  - On a read: assert the selected source's rd, load the output register with {data, eot, cur_src}, and increment word_cnt.
  - The unselected source is never read.
  - If the read word has eot=1 and !ord_empty: pop the next order entry in the same cycle, latch the new cur_src, clear word_cnt, and stay in XFER (no bubble).
  - If the read word has eot=1 and ord_empty: go to IDLE.
  - If word_cnt reaches MAX_TLV_WORDS with eot=0: emit that word with ob_tlast forced to 1, set merge_error, and go to DRAIN.
- DRAIN:
  - Pop the selected source whenever it is !empty, with no output load.
  - On the popped word with eot=1, return to IDLE.
- Output register:
  - Holds ob_tvalid/data stable until ob_tready.
  - If ob_tready and a new load occur in the same cycle, the register is replaced; throughput is 1 word per cycle.
- tlv_count increments on ob_tvalid & ob_tready & ob_tlast, including forced-tlast words. Wraps 0xFFFF -> 0.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; ob_tvalid, ob_tdata, ob_tlast, ob_tid, ord_rd, pt_rd, usr_rd, merge_error, tlv_count, word_cnt all go to 0.
  - A reset mid-TLV discards the partial TLV; ob_tvalid is 0 from the next cycle.
- The rd outputs are combinational from state and empty flags, and are never asserted while rst_n=0.
- Latency from IDLE with the order and data FIFOs both non-empty:
  - cycle 0: ord_rd.
  - cycle 1: source rd.
  - cycle 2: ob_tvalid=1.
- Back-to-back TLVs: the last word of TLV n and the first word of TLV n+1 appear on consecutive cycles.
- Selected source empty mid-TLV: no read. ob_tvalid falls after the held word is accepted, and resumes 1 cycle after the source becomes non-empty.
- Backpressure: ob_tready=0 with ob_tvalid=1 blocks all source reads; the output is held exactly.
- word_cnt width is $clog2(MAX_TLV_WORDS)+1. A TLV of exactly MAX_TLV_WORDS words ending in eot is legal.

## Test plan
- Order sequence pt,usr,pt; TLVs of 3, 1 and 2 words; ob_tready=1 throughout -> 6 words on 6 consecutive cycles after the first, ob_tid = 0,0,0,1,0,0, tlast on words 3, 4 and 6, tlv_count = 3.
- Order head usr, usr FIFO empty, pt FIFO non-empty -> pt_rd never asserted and ob_tvalid stays 0. usr word with eot=1 arrives -> emitted 1 cycle later with ob_tid=1.
- Random ob_tready at 50% over 1000 TLVs from both sources -> output equals the reference interleave word-for-word, no drop or duplicate, data stable while stalled.
- MAX_TLV_WORDS=4, pt TLV of 6 words -> 4 words out with tlast on word 4, merge_error=1, words 5-6 popped but not emitted, next TLV output correct.
- rst_n=0 for 1 cycle after 2 of 5 words of a TLV -> all outputs 0 next cycle; fresh ord/data after reset -> correct output, tlv_count restarts at 0.
- 65537 single-word TLVs -> tlv_count = 1 (wrap).

Source files
------------

// File: rtl/cr_tlvp_ob_merge.sv
// cr_tlvp_ob_merge: re-interleaves pass-through and user TLVs in arrival
// order onto one registered valid/ready stream, keeping each TLV atomic.
module cr_tlvp_ob_merge #(
  parameter int N_DATA_BITS   = 64,
  parameter int MAX_TLV_WORDS = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ord_empty,
  input  logic                   ord_src,
  output logic                   ord_rd,
  input  logic                   pt_empty,
  input  logic [N_DATA_BITS-1:0] pt_data,
  input  logic                   pt_eot,
  output logic                   pt_rd,
  input  logic                   usr_empty,
  input  logic [N_DATA_BITS-1:0] usr_data,
  input  logic                   usr_eot,
  output logic                   usr_rd,
  output logic                   ob_tvalid,
  input  logic                   ob_tready,
  output logic [N_DATA_BITS-1:0] ob_tdata,
  output logic                   ob_tlast,
  output logic                   ob_tid,
  output logic                   merge_error,
  output logic [15:0]            tlv_count
);

  localparam int CW = $clog2(MAX_TLV_WORDS) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TLV_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_t;

  state_t state, state_nxt;
  logic cur_src, cur_src_nxt;
  logic [CW-1:0] word_cnt, word_cnt_nxt, cnt_inc;
  logic sel_empty, sel_eot;
  logic [N_DATA_BITS-1:0] sel_data;
  logic can_load, load, over, src_rd;

  assign sel_empty = cur_src ? usr_empty : pt_empty;
  assign sel_eot   = cur_src ? usr_eot : pt_eot;
  assign sel_data  = cur_src ? usr_data : pt_data;
  assign can_load  = !ob_tvalid || ob_tready;
  assign cnt_inc   = word_cnt + CW'(1);
  assign pt_rd     = src_rd && !cur_src;
  assign usr_rd    = src_rd && cur_src;

  always_comb begin
    state_nxt    = state;
    cur_src_nxt  = cur_src;
    word_cnt_nxt = word_cnt;
    ord_rd       = 1'b0;
    src_rd       = 1'b0;
    load         = 1'b0;
    over         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ord_empty) begin
          ord_rd       = 1'b1;
          cur_src_nxt  = ord_src;
          word_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        if (!sel_empty && can_load) begin
          src_rd       = 1'b1;
          load         = 1'b1;
          word_cnt_nxt = cnt_inc;
          if (sel_eot) begin
            if (!ord_empty) begin
              ord_rd       = 1'b1;
              cur_src_nxt  = ord_src;
              word_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else if (cnt_inc == MAX_CNT) begin
            over      = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // discard the oversize tail without touching the output
        if (!sel_empty) begin
          src_rd = 1'b1;
          if (sel_eot) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      ord_rd = 1'b0;
      src_rd = 1'b0;
      load   = 1'b0;
      over   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_src     <= 1'b0;
      word_cnt    <= '0;
      ob_tvalid   <= 1'b0;
      ob_tdata    <= '0;
      ob_tlast    <= 1'b0;
      ob_tid      <= 1'b0;
      merge_error <= 1'b0;
      tlv_count   <= '0;
    end else begin
      state    <= state_nxt;
      cur_src  <= cur_src_nxt;
      word_cnt <= word_cnt_nxt;
      if (load) begin
        ob_tvalid <= 1'b1;
        ob_tdata  <= sel_data;
        ob_tlast  <= sel_eot || over;
        ob_tid    <= cur_src;
      end else if (ob_tready) begin
        ob_tvalid <= 1'b0;
      end
      if (over) merge_error <= 1'b1;
      if (ob_tvalid && ob_tready && ob_tlast)
        tlv_count <= tlv_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cr_tlvp_ob_merge.sv
// tb_cr_tlvp_ob_merge: scoreboard bench, FIFOs modelled as queues,
// outputs checked by a negedge monitor against the reference interleave.
module tb_cr_tlvp_ob_merge;

  localparam int W    = 64;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ord_empty, ord_src, ord_rd;
  logic pt_empty, pt_eot, pt_rd;
  logic usr_empty, usr_eot, usr_rd;
  logic [W-1:0] pt_data, usr_data, ob_tdata;
  logic ob_tvalid, ob_tready, ob_tlast, ob_tid, merge_error;
  logic [15:0] tlv_count;

  always #5 clk = ~clk;

  cr_tlvp_ob_merge #(
    .N_DATA_BITS  (W),
    .MAX_TLV_WORDS(MAXW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ord_empty  (ord_empty),
    .ord_src    (ord_src),
    .ord_rd     (ord_rd),
    .pt_empty   (pt_empty),
    .pt_data    (pt_data),
    .pt_eot     (pt_eot),
    .pt_rd      (pt_rd),
    .usr_empty  (usr_empty),
    .usr_data   (usr_data),
    .usr_eot    (usr_eot),
    .usr_rd     (usr_rd),
    .ob_tvalid  (ob_tvalid),
    .ob_tready  (ob_tready),
    .ob_tdata   (ob_tdata),
    .ob_tlast   (ob_tlast),
    .ob_tid     (ob_tid),
    .merge_error(merge_error),
    .tlv_count  (tlv_count)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         eot;
  } word_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         last;
    logic         id;
  } exp_t;

  word_t pt_q[$];
  word_t usr_q[$];
  logic  ord_q[$];
  exp_t  exp_q[$];
  int    acc_cyc[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pt_rd_seen = 0;
  int valid_seen = 0;
  logic rand_rdy = 1'b0;
  logic pop_pt = 1'b0, pop_usr = 1'b0, pop_ord = 1'b0;
  logic held_v = 1'b0;
  exp_t held;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void refresh();
    ord_empty = (ord_q.size() == 0);
    ord_src   = 1'b0;
    if (!ord_empty) ord_src = ord_q[0];
    pt_empty = (pt_q.size() == 0);
    pt_data  = '0;
    pt_eot   = 1'b0;
    if (!pt_empty) begin
      pt_data = pt_q[0].d;
      pt_eot  = pt_q[0].eot;
    end
    usr_empty = (usr_q.size() == 0);
    usr_data  = '0;
    usr_eot   = 1'b0;
    if (!usr_empty) begin
      usr_data = usr_q[0].d;
      usr_eot  = usr_q[0].eot;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // queue a TLV and its expected output, truncated at MAXW words
  task automatic push_tlv(input logic src, input int len,
                          input logic [W-1:0] base);
    word_t w;
    exp_t e;
    ord_q.push_back(src);
    for (int i = 0; i < len; i++) begin
      w.d   = base + W'(i);
      w.eot = (i == len - 1);
      if (src) usr_q.push_back(w);
      else pt_q.push_back(w);
      if (i < MAXW) begin
        e.d    = w.d;
        e.last = (i == len - 1) || (i == MAXW - 1);
        e.id   = src;
        exp_q.push_back(e);
      end
    end
    refresh();
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || pt_q.size() != 0 || usr_q.size() != 0 ||
            ord_q.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm,
               exp_q.size());
    end
    step(2);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (pop_ord && ord_q.size() != 0) ord_q.delete(0);
    if (pop_pt && pt_q.size() != 0) pt_q.delete(0);
    if (pop_usr && usr_q.size() != 0) usr_q.delete(0);
    ob_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    refresh();
  end

  always @(negedge clk) begin
    exp_t e;
    pop_pt  = pt_rd;
    pop_usr = usr_rd;
    pop_ord = ord_rd;
    if (pt_rd) pt_rd_seen++;
    if (ob_tvalid) valid_seen++;
    if (held_v) begin
      checks++;
      if (!ob_tvalid || {ob_tdata, ob_tlast, ob_tid} !== held) begin
        failures++;
        $display("FAIL hold: got v=%0b d=%0h expected v=1 d=%0h",
                 ob_tvalid, ob_tdata, held.d);
      end
    end
    if (ob_tvalid && ob_tready) begin
      acc_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word: got d=%0h with none expected", ob_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({ob_tdata, ob_tlast, ob_tid} !== e) begin
          failures++;
          $display("FAIL word: got d=%0h last=%0b id=%0b expected d=%0h last=%0b id=%0b",
                   ob_tdata, ob_tlast, ob_tid, e.d, e.last, e.id);
        end
      end
    end
    held_v = rst_n && ob_tvalid && !ob_tready;
    held   = {ob_tdata, ob_tlast, ob_tid};
  end

  initial begin
    int c0;
    word_t w;
    exp_t e;
    ob_tready = 1'b1;
    refresh();
    step(3);
    chk("rst_tvalid", 64'(ob_tvalid), 0);
    chk("rst_tdata", ob_tdata, 0);
    chk("rst_tlast", 64'(ob_tlast), 0);
    chk("rst_count", 64'(tlv_count), 0);
    chk("rst_err", 64'(merge_error), 0);
    rst_n = 1'b1;
    step(1);

    // pt(3), usr(1), pt(2) back to back
    acc_cyc.delete();
    c0 = cyc;
    push_tlv(1'b0, 3, 64'h100);
    push_tlv(1'b1, 1, 64'h200);
    push_tlv(1'b0, 2, 64'h300);
    wait_done(100, "t1");
    chk("t1_words", 64'(acc_cyc.size()), 6);
    if (acc_cyc.size() == 6) begin
      chk("t1_latency", 64'(acc_cyc[0]), 64'(c0 + 2));
      chk("t1_b2b", 64'(acc_cyc[5] - acc_cyc[0]), 5);
    end
    chk("t1_count", 64'(tlv_count), 3);

    // usr selected but empty: pt must not be touched
    pt_rd_seen = 0;
    valid_seen = 0;
    ord_q.push_back(1'b1);
    w.d = 64'h400;
    w.eot = 1'b1;
    pt_q.push_back(w);
    refresh();
    step(10);
    chk("t2_no_pt_rd", 64'(pt_rd_seen), 0);
    chk("t2_no_valid", 64'(valid_seen), 0);
    acc_cyc.delete();
    c0 = cyc;
    w.d = 64'h500;
    usr_q.push_back(w);
    e.d = 64'h500;
    e.last = 1'b1;
    e.id = 1'b1;
    exp_q.push_back(e);
    ord_q.push_back(1'b0);
    e.d = 64'h400;
    e.id = 1'b0;
    exp_q.push_back(e);
    refresh();
    wait_done(100, "t2");
    chk("t2_words", 64'(acc_cyc.size()), 2);
    if (acc_cyc.size() != 0) chk("t2_latency", 64'(acc_cyc[0]), 64'(c0 + 1));

    // random backpressure, mixed sources and lengths
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++)
      push_tlv(1'($urandom_range(0, 1)), int'($urandom_range(1, MAXW)),
               64'(k + 1) << 8);
    wait_done(30000, "t3");
    rand_rdy = 1'b0;
    step(1);
    chk("t3_err", 64'(merge_error), 0);
    chk("t3_count", 64'(tlv_count), 1005);

    // oversize TLV truncated, tail drained, next TLV intact
    push_tlv(1'b0, 6, 64'hA000);
    push_tlv(1'b1, 2, 64'hB000);
    wait_done(200, "t4");
    chk("t4_err", 64'(merge_error), 1);
    chk("t4_count", 64'(tlv_count), 1007);

    // reset in the middle of a TLV
    ord_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      w.d = 64'hD00 + 64'(i);
      w.eot = 1'b0;
      pt_q.push_back(w);
      e.d = w.d;
      e.last = 1'b0;
      e.id = 1'b0;
      exp_q.push_back(e);
    end
    refresh();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) step(1);
    chk("t5_partial", 64'(exp_q.size()), 0);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    ord_q.delete();
    pt_q.delete();
    usr_q.delete();
    exp_q.delete();
    refresh();
    @(negedge clk);
    #1;
    chk("t5_tvalid", 64'(ob_tvalid), 0);
    chk("t5_tdata", ob_tdata, 0);
    chk("t5_err", 64'(merge_error), 0);
    chk("t5_count", 64'(tlv_count), 0);
    step(1);
    push_tlv(1'b1, 2, 64'hC000);
    wait_done(100, "t5");
    chk("t5_count_after", 64'(tlv_count), 1);

    // tlv_count wrap
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < 65537; k++) push_tlv(1'b0, 1, 64'(k));
    wait_done(70000, "t6");
    chk("t6_wrap", 64'(tlv_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
